wb_flash_ctrl: RTL and testbench
================================

# wb_flash_ctrl

Parametrised Wishbone classic slave that bridges the 32-bit system bus to an asynchronous parallel NOR flash. It supports 8- or 16-bit flash data buses with independently configurable read and write wait states. It adds single-lane flash write cycles for command, program and erase sequences, and signals illegal accesses with `wb_err_o`. It sits on the system Wishbone interconnect in place of the fixed-width, read-only flash controller.

## Interface
- `FLASH_DW`, 8: flash data width, 8 or 16; `BEATS = 32/FLASH_DW`.
- `FLASH_AW`, 23: flash address width, in flash-word units.
- `RD_WAIT`, 6: cycles per read beat, ≥1.
- `WR_WAIT`, 6: `flash_we` low-pulse width in cycles, ≥1.
- `WRITE_EN`, 1: 0 makes every write return `wb_err_o`.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wb_adr_i` in 32: byte address; bits [1:0] ignored.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data, valid with `wb_ack_o`.
- `wb_sel_i` in 4: byte lanes.
- `wb_we_i` in 1: 1 = write.
- `wb_stb_i`, `wb_cyc_i` in 1 each: request when both are high (`acc`).
- `wb_ack_o` out 1: one-cycle normal termination.
- `wb_err_o` out 1: one-cycle error termination.
- `flash_adr_o` out FLASH_AW: flash address.
- `flash_dat_i` in FLASH_DW: read data from the pad.
- `flash_dat_o` out FLASH_DW: write data to the pad.
- `flash_dat_oe` out 1: 1 = pad driven by the controller.
- `flash_ce`, `flash_oe`, `flash_we` out 1 each: active-low strobes.
- `flash_rst` out 1: `!wb_rst_i`, combinational.

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK, ERR. All outputs except `flash_rst` are registered.
- IDLE:
  - `acc` & !we → RD; beat=0, wait counter=0.
  - `acc` & we & valid lane & WRITE_EN → WR_SETUP.
  - `acc` & we & (invalid lane | !WRITE_EN) → ERR.
- Flash address: `(wb_adr_i[31:2]*BEATS + beat)` truncated to FLASH_AW.
- RD:
  - `flash_ce`=0, `flash_oe`=0, `flash_dat_oe`=0.
  - When counter == RD_WAIT-1, sample `flash_dat_i` into the beat's lane. Beat 0 goes to the most significant bits (big-endian).
  - Then increment beat and clear the counter; after the last beat → ACK.
  - `wb_sel_i` is ignored on reads; the full word is always fetched.
- Valid write lane:
  - FLASH_DW=8: `wb_sel_i` one-hot.
  - FLASH_DW=16: `wb_sel_i` is 4'b1100 or 4'b0011.
  - Lane index is 0 for the most significant lane. `beat` = lane index; `flash_dat_o` = the selected lane of `wb_dat_i`.
- Write sequence:
  - WR_SETUP, 1 cycle: address/data stable, `flash_ce`=0, `flash_dat_oe`=1, `flash_we`=1.
  - WR_PULSE, WR_WAIT cycles: `flash_we`=0.
  - WR_HOLD, 1 cycle: `flash_we`=1, data still driven.
  - → ACK.
- ACK/ERR: assert `wb_ack_o`/`wb_err_o` for one cycle, then → IDLE. The master deasserts `stb` after termination; IDLE re-samples the next cycle.
- Abort: `acc` low in any non-IDLE state → IDLE at the next edge, no termination. Strobes return high, `flash_dat_oe`=0.
- `wb_dat_o` holds its last value outside reads; it is not cleared on abort.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `flash_adr_o`=0, `flash_dat_o`=0, `flash_dat_oe`=0, `flash_ce`=1, `flash_oe`=1, `flash_we`=1, state IDLE.
- Reset mid-cycle takes priority: all the above apply at the next edge, and `flash_we` is never left low.
- Request first sampled at edge 0. Beat-0 address and strobes are visible from cycle 1.
- Read: `wb_ack_o` high in cycle `1 + BEATS*RD_WAIT`; defaults give 25. Beat k is sampled at the end of cycle `(k+1)*RD_WAIT`.
- Write: `wb_ack_o` high in cycle `3 + WR_WAIT`.
- Error: `wb_err_o` high in cycle 1; no flash strobe is asserted.
- `flash_adr_o` changes only when `flash_we`=1. Data is stable from WR_SETUP through WR_HOLD inclusive.
- `wb_ack_o` and `wb_err_o` are never high together.

## Structure
- Package `flash_pkg`:
  - state encoding;
  - `BEATS`;
  - the function returning the lane index and validity from `wb_sel_i` and FLASH_DW.
- One sub-module, `flash_wait_counter`: a loadable down-counter with a `done` pulse, shared by RD beats and WR_PULSE; width `$clog2(max(RD_WAIT,WR_WAIT)+1)`.

## Test plan
- **8-bit read:** FLASH_DW=8, RD_WAIT=6; read 0x0000_0010 with flash model bytes 0x11,0x22,0x33,0x44 at addresses 0x10..0x13 → `wb_dat_o`=0x11223344, ack in cycle 25.
- **16-bit read:** FLASH_DW=16, RD_WAIT=3; read 0x8 with halfwords 0xABCD@4, 0x1234@5 → 0xABCD1234, ack in cycle 7.
- **8-bit write:** write 0x0000_0AAA, sel=4'b0010, dat=0x0000_5500 → `flash_adr_o`=0xAAA (word 0x2AA × 4 + lane 2), `flash_dat_o`=0x55. `flash_we` low for exactly WR_WAIT cycles; ack in cycle 3+WR_WAIT.
- **Invalid writes:** write with sel=4'b0011 at FLASH_DW=8 → err in cycle 1, no `flash_we`/`flash_ce` activity. Same with WRITE_EN=0 and a valid sel → err.
- **Abort:** drop `wb_stb_i` mid-read at beat 2, and separately mid-WR_PULSE → next edge IDLE, `flash_we`=1, `flash_ce`=1, no ack/err. A following read completes normally.
- **Reset mid-write:** assert `wb_rst_i` during WR_PULSE → next edge all outputs at reset values, `flash_rst`=0 combinationally while reset is high.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and helpers for the Wishbone-to-parallel-NOR flash bridge.
package flash_pkg;

    localparam int unsigned BUS_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_ACK,
        ST_ERR
    } flash_state_e;

    // Lane 0 is the most significant flash-width slice of the bus word.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } lane_t;

    function automatic int unsigned flash_beats(input int unsigned dw);
        return BUS_DW / dw;
    endfunction

    function automatic lane_t lane_decode(input logic [3:0] sel, input int unsigned dw);
        lane_t l;
        l = '0;
        if (dw == 16) begin
            case (sel)
                4'b1100: begin l.valid = 1'b1; l.idx = 2'd0; end
                4'b0011: begin l.valid = 1'b1; l.idx = 2'd1; end
                default: ;
            endcase
        end else begin
            case (sel)
                4'b1000: begin l.valid = 1'b1; l.idx = 2'd0; end
                4'b0100: begin l.valid = 1'b1; l.idx = 2'd1; end
                4'b0010: begin l.valid = 1'b1; l.idx = 2'd2; end
                4'b0001: begin l.valid = 1'b1; l.idx = 2'd3; end
                default: ;
            endcase
        end
        return l;
    endfunction

endpackage

// File: rtl/flash_wait_counter.sv
// Loadable down-counter timing read beats and the write-enable pulse.
module flash_wait_counter #(
    parameter int unsigned W = 3
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Pulses in the last cycle of the loaded interval.
    assign done_c = dec && (cnt_q == '0);

endmodule

// File: rtl/wb_flash_ctrl.sv
// Wishbone classic slave bridging the 32-bit bus to an 8/16-bit asynchronous NOR flash.
module wb_flash_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned FLASH_DW = 8,
    parameter int unsigned FLASH_AW = 23,
    parameter int unsigned RD_WAIT  = 6,
    parameter int unsigned WR_WAIT  = 6,
    parameter bit          WRITE_EN = 1'b1
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic [FLASH_AW-1:0] flash_adr_o,
    input  logic [FLASH_DW-1:0] flash_dat_i,
    output logic [FLASH_DW-1:0] flash_dat_o,
    output logic                flash_dat_oe,
    output logic                flash_ce,
    output logic                flash_oe,
    output logic                flash_we,
    output logic                flash_rst
);

    localparam int unsigned BEATS    = flash_beats(FLASH_DW);
    localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int unsigned CW       = $clog2(MAX_WAIT + 1);

    flash_state_e        state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                ack_d, err_d, ce_d, oe_d, we_d, dat_oe_d;
    logic [31:0]         rdat_d;
    logic [FLASH_AW-1:0] adr_d;
    logic [FLASH_DW-1:0] wdat_d;
    logic                cnt_load, cnt_dec, cnt_done_c;
    logic [CW-1:0]       cnt_val;
    logic [31:0]         word_base;
    logic                acc;
    lane_t               lane;
    logic                unused_adr_lsb;

    assign acc            = wb_stb_i & wb_cyc_i;
    assign lane           = lane_decode(wb_sel_i, FLASH_DW);
    assign word_base      = 32'(wb_adr_i[31:2]) * 32'(BEATS);
    assign flash_rst      = !wb_rst_i;
    assign unused_adr_lsb = ^wb_adr_i[1:0];

    flash_wait_counter #(.W(CW)) u_wait (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .done_c   (cnt_done_c)
    );

    // State and registered outputs; every output below is the next-cycle value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            flash_adr_o  <= '0;
            flash_dat_o  <= '0;
            flash_dat_oe <= 1'b0;
            flash_ce     <= 1'b1;
            flash_oe     <= 1'b1;
            flash_we     <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            wb_dat_o     <= rdat_d;
            flash_adr_o  <= adr_d;
            flash_dat_o  <= wdat_d;
            flash_dat_oe <= dat_oe_d;
            flash_ce     <= ce_d;
            flash_oe     <= oe_d;
            flash_we     <= we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        ce_d     = 1'b1;
        oe_d     = 1'b1;
        we_d     = 1'b1;
        dat_oe_d = 1'b0;
        rdat_d   = wb_dat_o;
        adr_d    = flash_adr_o;
        wdat_d   = flash_dat_o;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (!wb_we_i) begin
                        state_d  = ST_RD;
                        beat_d   = '0;
                        adr_d    = FLASH_AW'(word_base);
                        ce_d     = 1'b0;
                        oe_d     = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(RD_WAIT - 1);
                    end else if (lane.valid && WRITE_EN) begin
                        state_d  = ST_WR_SETUP;
                        beat_d   = lane.idx;
                        adr_d    = FLASH_AW'(word_base + 32'(lane.idx));
                        wdat_d   = wb_dat_i[FLASH_DW*(BEATS-1-32'(lane.idx)) +: FLASH_DW];
                        ce_d     = 1'b0;
                        dat_oe_d = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (!acc) begin
                    state_d = ST_IDLE;
                end else begin
                    ce_d    = 1'b0;
                    oe_d    = 1'b0;
                    cnt_dec = 1'b1;
                    // Beat 0 lands in the most significant slice (big-endian).
                    if (cnt_done_c) begin
                        rdat_d[FLASH_DW*(BEATS-1-32'(beat_q)) +: FLASH_DW] = flash_dat_i;
                        if (beat_q == 2'(BEATS - 1)) begin
                            state_d = ST_ACK;
                            ack_d   = 1'b1;
                            ce_d    = 1'b1;
                            oe_d    = 1'b1;
                        end else begin
                            beat_d   = beat_q + 2'd1;
                            adr_d    = FLASH_AW'(word_base + 32'(beat_q) + 32'd1);
                            cnt_load = 1'b1;
                            cnt_val  = CW'(RD_WAIT - 1);
                        end
                    end
                end
            end
            ST_WR_SETUP: begin
                if (!acc) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_WR_PULSE;
                    ce_d     = 1'b0;
                    dat_oe_d = 1'b1;
                    we_d     = 1'b0;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(WR_WAIT - 1);
                end
            end
            ST_WR_PULSE: begin
                if (!acc) begin
                    state_d = ST_IDLE;
                end else begin
                    ce_d     = 1'b0;
                    dat_oe_d = 1'b1;
                    cnt_dec  = 1'b1;
                    if (cnt_done_c) begin
                        state_d = ST_WR_HOLD;
                    end else begin
                        we_d = 1'b0;
                    end
                end
            end
            ST_WR_HOLD: begin
                if (!acc) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                end
            end
            ST_ACK, ST_ERR: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_flash_ctrl.sv
// Randomized self-checking bench: an 8-bit writable instance and a 16-bit read-only instance.
module tb_wb_flash_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr, wb_wdat;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, stb8, stb16;

    logic [31:0] dat8, dat16;
    logic        ack8, err8, ack16, err16;
    logic [22:0] fadr8, fadr16;
    logic [7:0]  fdi8, fdo8;
    logic [15:0] fdi16, fdo16;
    logic        fdoe8, fce8, foe8, fwe8, frst8;
    logic        fdoe16, fce16, foe16, fwe16, frst16;

    logic [7:0]  mem8 [256];
    logic [15:0] mem16 [256];
    logic [7:0]  ref8 [256];
    logic [15:0] ref16 [256];

    int unsigned n_cmp = 0, n_bad = 0, viol = 0;
    int unsigned we_run8 = 0, we_low8 = 0, ce_low8 = 0, last_pulse8 = 0;
    int unsigned we_low16 = 0, ce_low16 = 0;
    logic [22:0] last_wadr8 = '0, padr8 = '0, padr16 = '0;
    logic [7:0]  last_wdat8 = '0, pdo8 = '0;
    logic        pwe8 = 1'b1, pwe16 = 1'b1, pdoe8 = 1'b0;
    bit          mem_init = 1'b0;

    always #5 clk = ~clk;

    wb_flash_ctrl #(.FLASH_DW(8), .FLASH_AW(23), .RD_WAIT(6), .WR_WAIT(6), .WRITE_EN(1'b1)) dut8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_dat_o(dat8),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_stb_i(stb8), .wb_cyc_i(wb_cyc),
        .wb_ack_o(ack8), .wb_err_o(err8), .flash_adr_o(fadr8), .flash_dat_i(fdi8),
        .flash_dat_o(fdo8), .flash_dat_oe(fdoe8), .flash_ce(fce8), .flash_oe(foe8),
        .flash_we(fwe8), .flash_rst(frst8)
    );

    wb_flash_ctrl #(.FLASH_DW(16), .FLASH_AW(23), .RD_WAIT(3), .WR_WAIT(2), .WRITE_EN(1'b0)) dut16 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_dat_o(dat16),
        .wb_sel_i(wb_sel), .wb_we_i(wb_we), .wb_stb_i(stb16), .wb_cyc_i(wb_cyc),
        .wb_ack_o(ack16), .wb_err_o(err16), .flash_adr_o(fadr16), .flash_dat_i(fdi16),
        .flash_dat_o(fdo16), .flash_dat_oe(fdoe16), .flash_ce(fce16), .flash_oe(foe16),
        .flash_we(fwe16), .flash_rst(frst16)
    );

    // Asynchronous flash devices: data follows the address, writes latch on the rising flash_we.
    assign fdi8  = mem8[fadr8[7:0]];
    assign fdi16 = mem16[fadr16[7:0]];

    function automatic logic [7:0] init_byte(input int i);
        if (i >= 16 && i <= 19) return 8'((i - 15) * 17);
        return 8'((i * 29 + 7) ^ (i >> 3));
    endfunction

    function automatic logic [15:0] init_half(input int i);
        if (i == 4) return 16'hABCD;
        if (i == 5) return 16'h1234;
        return 16'((i * 4099 + 321) ^ (i << 9));
    endfunction

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem8[i]  = init_byte(i);
                mem16[i] = init_half(i);
            end
            mem_init = 1'b1;
        end
        if (!fwe8) begin
            we_run8++;
            we_low8++;
            if (fadr8 !== padr8) viol++;
        end
        if (pdoe8 && fdoe8 && (fdo8 !== pdo8)) viol++;
        if (!pwe8 && fwe8) begin
            last_pulse8 = we_run8;
            we_run8     = 0;
            if (fdoe8) begin
                mem8[fadr8[7:0]] = fdo8;
                last_wadr8       = fadr8;
                last_wdat8       = fdo8;
            end
        end
        if (!fce8) ce_low8++;
        if (!fwe16) begin
            we_low16++;
            if (fadr16 !== padr16) viol++;
        end
        if (!pwe16 && fwe16 && fdoe16) mem16[fadr16[7:0]] = fdo16;
        if (!fce16) ce_low16++;
        if ((ack8 && err8) || (ack16 && err16)) viol++;
        pwe8 = fwe8; padr8 = fadr8; pdoe8 = fdoe8; pdo8 = fdo8;
        pwe16 = fwe16; padr16 = fadr16;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd8(input int w);
        return {ref8[(w*4)&255], ref8[(w*4+1)&255], ref8[(w*4+2)&255], ref8[(w*4+3)&255]};
    endfunction

    function automatic logic [31:0] ref_rd16(input int w);
        return {ref16[(w*2)&255], ref16[(w*2+1)&255]};
    endfunction

    // One Wishbone transaction; cyc is the cycle (edge 0 = first sample) in which ack/err appeared, 0 on timeout.
    task automatic wb_txn(input int d, input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic ack, output logic err,
                          output int cyc, output logic [31:0] rdat);
        @(negedge clk);
        wb_adr = adr; wb_we = we; wb_sel = sel; wb_wdat = dat; wb_cyc = 1'b1;
        if (d == 0) stb8 = 1'b1; else stb16 = 1'b1;
        ack = 1'b0; err = 1'b0; cyc = 0; rdat = '0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (d == 0) begin ack = ack8; err = err8; rdat = dat8; end
            else begin ack = ack16; err = err16; rdat = dat16; end
            if (ack || err) begin
                cyc = c;
                break;
            end
        end
        stb8 = 1'b0; stb16 = 1'b0; wb_cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    logic        a, e;
    int          c, lane, fa;
    logic [31:0] r, d;
    logic [3:0]  s;
    int unsigned snap_we, snap_ce, term;

    initial begin
        rst = 1'b1; wb_adr = '0; wb_wdat = '0; wb_sel = '0; wb_we = 1'b0;
        wb_cyc = 1'b0; stb8 = 1'b0; stb16 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ref8[i]  = init_byte(i);
            ref16[i] = init_half(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_dat", dat8, 32'd0);
        check("rst_adr", 32'(fadr8), 32'd0);
        check("rst_strobes", {29'd0, fce8, foe8, fwe8}, 32'd7);
        check("rst_doe", 32'(fdoe8), 32'd0);
        check("rst_flash_rst", 32'(frst8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flash_rst_run", 32'(frst8), 32'd1);

        // Directed reads and writes
        wb_txn(0, 1'b0, 32'h10, 4'hF, 32'h0, a, e, c, r);
        check("rd8_data", r, 32'h1122_3344);
        check("rd8_cyc", 32'(c), 32'd25);

        wb_txn(1, 1'b0, 32'h8, 4'h0, 32'h0, a, e, c, r);
        check("rd16_data", r, 32'hABCD_1234);
        check("rd16_cyc", 32'(c), 32'd7);

        snap_we = we_low8;
        wb_txn(0, 1'b1, 32'h0AAA, 4'b0010, 32'h0000_5500, a, e, c, r);
        ref8[8'hAA] = 8'h55;
        check("wr8_ack", 32'(a), 32'd1);
        check("wr8_cyc", 32'(c), 32'd9);
        check("wr8_adr", 32'(last_wadr8), 32'h0AAA);
        check("wr8_dat", 32'(last_wdat8), 32'h55);
        check("wr8_pulse", last_pulse8, 32'd6);
        check("wr8_we_cycles", we_low8 - snap_we, 32'd6);

        snap_we = we_low8; snap_ce = ce_low8;
        wb_txn(0, 1'b1, 32'h40, 4'b0011, 32'hDEAD_BEEF, a, e, c, r);
        check("badsel_err", {30'd0, a, e}, 32'd1);
        check("badsel_cyc", 32'(c), 32'd1);
        check("badsel_strobes", (we_low8 - snap_we) + (ce_low8 - snap_ce), 32'd0);

        snap_we = we_low16; snap_ce = ce_low16;
        wb_txn(1, 1'b1, 32'h20, 4'b1100, 32'h1234_5678, a, e, c, r);
        check("wrdis_err", {30'd0, a, e}, 32'd1);
        check("wrdis_cyc", 32'(c), 32'd1);
        check("wrdis_strobes", (we_low16 - snap_we) + (ce_low16 - snap_ce), 32'd0);

        // Abort a read during beat 2
        @(negedge clk);
        wb_adr = 32'h14; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; stb8 = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("abrd_beat2_adr", 32'(fadr8), 32'd22);
        check("abrd_active", {30'd0, fce8, foe8}, 32'd0);
        stb8 = 1'b0; wb_cyc = 1'b0;
        @(posedge clk); #1;
        check("abrd_idle", {28'd0, fce8, foe8, fwe8, fdoe8}, 32'hE);
        term = 0;
        for (int i = 0; i < 4; i++) begin
            term += 32'(ack8 | err8);
            @(posedge clk); #1;
        end
        check("abrd_noterm", term, 32'd0);
        wb_txn(0, 1'b0, 32'h1C, 4'hF, 32'h0, a, e, c, r);
        check("abrd_next_data", r, ref_rd8(7));
        check("abrd_next_cyc", 32'(c), 32'd25);

        // Abort a write during the flash_we pulse
        @(negedge clk);
        wb_adr = 32'h31; wb_we = 1'b1; wb_sel = 4'b0100; wb_wdat = 32'h00A5_0000; wb_cyc = 1'b1; stb8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abwr_pulse", 32'(fwe8), 32'd0);
        stb8 = 1'b0; wb_cyc = 1'b0;
        @(posedge clk); #1;
        check("abwr_idle", {29'd0, fce8, fwe8, fdoe8}, 32'h6);
        term = 0;
        for (int i = 0; i < 4; i++) begin
            term += 32'(ack8 | err8);
            @(posedge clk); #1;
        end
        check("abwr_noterm", term, 32'd0);

        // Reset during the flash_we pulse
        @(negedge clk);
        wb_adr = 32'h80; wb_we = 1'b1; wb_sel = 4'b1000; wb_wdat = 32'h7700_0000; wb_cyc = 1'b1; stb8 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rstwr_pulse", 32'(fwe8), 32'd0);
        rst = 1'b1;
        #1;
        check("rstwr_flash_rst", {30'd0, frst8, frst16}, 32'd0);
        @(posedge clk); #1;
        check("rstwr_strobes", {28'd0, fce8, foe8, fwe8, fdoe8}, 32'hE);
        check("rstwr_term", {30'd0, ack8, err8}, 32'd0);
        check("rstwr_adr_dat", {1'b0, fadr8, fdo8}, 32'd0);
        check("rstwr_rdat", dat8, 32'd0);
        check("rstwr_dut16", {28'd0, fce16, foe16, fwe16, fdoe16}, 32'hE);
        stb8 = 1'b0; wb_cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the reference memories
        for (int n = 0; n < 40; n++) begin
            int w;
            w = int'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 0) begin
                wb_txn(0, 1'b0, 32'(w * 4), 4'($urandom), 32'h0, a, e, c, r);
                check("rnd8_rd_data", r, ref_rd8(w));
                check("rnd8_rd_cyc", 32'(c), 32'd25);
            end else begin
                s = ($urandom_range(0, 9) < 7) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
                d = $urandom;
                wb_txn(0, 1'b1, 32'(w * 4) | 32'($urandom_range(0, 3)), s, d, a, e, c, r);
                if ($countones(s) == 1) begin
                    lane = 0;
                    for (int k = 0; k < 4; k++) if (s[3-k]) lane = k;
                    fa = (w * 4 + lane) & 255;
                    ref8[fa] = 8'(d >> (8 * (3 - lane)));
                    check("rnd8_wr_ack", {30'd0, a, e}, 32'd2);
                    check("rnd8_wr_cyc", 32'(c), 32'd9);
                    check("rnd8_wr_adr", 32'(last_wadr8), 32'(fa));
                    check("rnd8_wr_mem", 32'(mem8[fa]), 32'(ref8[fa]));
                    check("rnd8_wr_pulse", last_pulse8, 32'd6);
                end else begin
                    check("rnd8_badsel", {30'd0, a, e}, 32'd1);
                    check("rnd8_badsel_cyc", 32'(c), 32'd1);
                end
            end
        end

        for (int n = 0; n < 16; n++) begin
            int w;
            w = int'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                wb_txn(1, 1'b0, 32'(w * 4), 4'($urandom), 32'h0, a, e, c, r);
                check("rnd16_rd_data", r, ref_rd16(w));
                check("rnd16_rd_cyc", 32'(c), 32'd7);
            end else begin
                wb_txn(1, 1'b1, 32'(w * 4), 4'($urandom), $urandom, a, e, c, r);
                check("rnd16_wr_err", {30'd0, a, e}, 32'd1);
                check("rnd16_wr_cyc", 32'(c), 32'd1);
            end
        end

        check("bus_protocol_violations", viol, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
